// File: rtl/pkt_tx_fifo.sv
// pkt_tx_fifo: store-and-forward packet buffer feeding one crossbar slave port;
// packets are released only once complete, oversized packets are truncated and flagged.
module pkt_tx_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DEST_WIDTH = 2,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [T_DATA_WIDTH-1:0]   wr_data_i,
  input  logic [T_DEST_WIDTH-1:0]   wr_dest_i,
  input  logic                      wr_last_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  output logic [T_DATA_WIDTH-1:0]   m_data_o,
  output logic [T_DEST_WIDTH-1:0]   m_dest_o,
  output logic                      m_last_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [$clog2(DEPTH):0]    pkt_count_o,
  output logic                      err_trunc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
  state_t                  r_state, w_state_nxt;
  logic [T_DATA_WIDTH-1:0] r_data [DEPTH];
  logic [T_DEST_WIDTH-1:0] r_dest [DEPTH];
  logic                    r_last [DEPTH];
  logic [PW-1:0]           r_wptr, r_rptr, r_level, r_pkt_count;
  logic [T_DEST_WIDTH-1:0] r_cur_dest;
  logic                    r_err;
  logic                    w_full, w_acc, w_store, w_rd, w_trunc, w_last_st;
  logic [T_DEST_WIDTH-1:0] w_st_dest;
  logic [AW-1:0]           w_widx, w_ridx;
  assign w_widx     = r_wptr[AW-1:0];
  assign w_ridx     = r_rptr[AW-1:0];
  assign w_full     = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);
  assign wr_ready_o = (r_state == DROP) || !w_full;
  assign w_acc      = wr_valid_i && wr_ready_o;
  assign w_store    = w_acc && (r_state != DROP);
  assign m_valid_o  = r_pkt_count != '0;
  assign w_rd       = m_valid_o && m_ready_i;
  // With no complete packet stored nothing can drain, so the last free slot must close the packet
  assign w_trunc    = w_store && !wr_last_i && (r_level == PW'(DEPTH - 1)) && (r_pkt_count == '0);
  assign w_last_st  = wr_last_i || w_trunc;
  assign w_st_dest  = (r_state == IDLE) ? wr_dest_i : r_cur_dest;
  assign m_data_o    = r_data[w_ridx];
  assign m_dest_o    = r_dest[w_ridx];
  assign m_last_o    = r_last[w_ridx];
  assign level_o     = r_level;
  assign pkt_count_o = r_pkt_count;
  assign err_trunc_o = r_err;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == DROP)
      w_state_nxt = (w_acc && wr_last_i) ? IDLE : DROP;
    else if (w_store)
      w_state_nxt = w_trunc ? DROP : (wr_last_i ? IDLE : BODY);
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wptr      <= r_wptr + PW'(w_store);
      r_rptr      <= r_rptr + PW'(w_rd);
      r_level     <= r_level + PW'(w_store) - PW'(w_rd);
      r_pkt_count <= r_pkt_count + PW'(w_store && w_last_st) - PW'(w_rd && m_last_o);
      r_err       <= w_trunc;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_store) r_cur_dest <= wr_dest_i;
    if (w_store) begin
      r_data[w_widx] <= wr_data_i;
      r_dest[w_widx] <= w_st_dest;
      r_last[w_widx] <= w_last_st;
    end
  end
endmodule

// File: doc/pkt_tx_fifo.md
# pkt_tx_fifo

Store-and-forward packet transmit buffer that feeds one slave port of the streaming crossbar. A producer writes packet beats (data, dest, last). The block presents them on a crossbar-compatible slave stream (data, dest, last, valid, ready) only once the whole packet has been stored, so a granted crossbar path is never stalled mid-packet by a slow producer. Oversized packets are truncated and flagged rather than deadlocking the buffer.

## Interface
- T_DATA_WIDTH, 8, data beat width
- T_DEST_WIDTH, 2, crossbar destination width
- DEPTH, 16, buffer entries; power of two, ≥ 2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-high reset (name kept for codebase consistency; 1 = reset)
- wr_data_i  in  T_DATA_WIDTH  producer beat data
- wr_dest_i  in  T_DEST_WIDTH  producer destination; sampled on first beat of a packet only
- wr_last_i  in  1  producer end-of-packet
- wr_valid_i  in  1  producer beat valid
- wr_ready_o  out  1  beat accepted when wr_valid_i & wr_ready_o
- m_data_o  out  T_DATA_WIDTH  to crossbar s_data_i slice
- m_dest_o  out  T_DEST_WIDTH  to crossbar s_dest_i slice
- m_last_o  out  1  to crossbar s_last_i bit
- m_valid_o  out  1  to crossbar s_valid_i bit
- m_ready_i  in  1  from crossbar s_ready_o bit
- level_o  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH
- pkt_count_o  out  $clog2(DEPTH)+1  complete packets stored
- err_trunc_o  out  1  one-cycle pulse on truncation

## Operation
- Storage: DEPTH entries of {data, dest, last}; write and read pointers of $clog2(DEPTH)+1 bits (extra wrap bit). Empty = pointers equal. Full = low bits equal, wrap bits differ.
- Write FSM states:
  - IDLE: next accepted beat is a packet's first beat. Latch wr_dest_i into cur_dest; store the beat with wr_dest_i. Go to BODY if wr_last_i=0; stay in IDLE if 1.
  - BODY: store the beat with cur_dest; wr_dest_i is ignored. Go to IDLE on an accepted last beat.
  - DROP: wr_ready_o=1. Beats are accepted and discarded. Go to IDLE on an accepted beat with wr_last_i=1.
- wr_ready_o = !full in IDLE/BODY; 1 in DROP.
- Truncation: in IDLE or BODY, an accepted non-last beat that makes level = DEPTH while pkt_count_o = 0 (no complete packet would ever drain) is stored with last forced to 1.
  - That cycle: pkt_count increments, err_trunc_o pulses next cycle, FSM goes to DROP.
  - If full with pkt_count_o > 0, wr_ready_o simply deasserts; no truncation.
- Read: m_valid_o = (pkt_count_o != 0). m_data_o/m_dest_o/m_last_o show the head entry (first-word-fall-through). A beat transfers when m_valid_o & m_ready_i.
- pkt_count_o: +1 on each stored entry with last=1; −1 on each transferred beat with m_last_o=1. Both in one cycle: unchanged.
- level_o: +1 on store, −1 on transfer; both in one cycle: unchanged.
- Pointers wrap modulo 2·DEPTH. No other state depends on wrap.

## Timing
- Reset (rst_n=1 at clk edge): pointers 0, level_o=0, pkt_count_o=0, FSM=IDLE, m_valid_o=0, wr_ready_o=1, err_trunc_o=0. m_data_o/m_dest_o/m_last_o are don't-care while m_valid_o=0.
- Reset mid-packet discards all stored and partial data. Reset has priority over simultaneous reads and writes.
- Latency: a last beat stored at edge N gives m_valid_o=1 after edge N, i.e. valid in cycle N+1. First beat out in cycle N+1, one beat per cycle while m_ready_i=1.
- m_valid_o and the head beat stay stable while m_ready_i=0. m_valid_o never depends on m_ready_i.
- Simultaneous write and read when full is allowed only via the read: wr_ready_o reflects the registered full state, with no combinational path from m_ready_i to wr_ready_o.
- Back-to-back packets: the first beat of packet k+1 may be accepted in the cycle after packet k's last beat. Output packets are contiguous when m_ready_i=1.

## Test plan
- Single packet: DEPTH=16. Write 3 beats 0xA1,0xA2,0xA3, dest=2 on beat 1 and dest=1 on beats 2–3, last on 0xA3, m_ready_i=0. Required: m_valid_o=0 until the cycle after 0xA3 is stored, then 1; level_o=3, pkt_count_o=1. With m_ready_i=1: outputs 0xA1,0xA2,0xA3, all m_dest_o=2, m_last_o=1 only on 0xA3; afterwards m_valid_o=0, level_o=0.
- Backpressure: hold m_ready_i=0 for 5 cycles with a packet pending. Required: head beat and m_valid_o stable; no beat lost or duplicated.
- Simultaneous: store the last beat of packet B in the same cycle as reading the last beat of packet A. Required: pkt_count_o stays 1, level_o correct.
- Full, no truncation: one 4-beat packet stored, then 12 non-last beats. Required: wr_ready_o=0 at level 16, no err_trunc_o. Draining 4 beats restores wr_ready_o.
- Oversized packet: 20-beat packet with empty buffer. Required: beat 16 is stored with last=1; err_trunc_o pulses once; beats 17–20 are accepted and dropped; 16 beats are output with last on the 16th; FSM back in IDLE.
- Reset mid-packet: reset after 2 of 4 beats. Required: level_o=0, m_valid_o=0, wr_ready_o=1; the next packet transfers intact.
